// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and the default iteration count.
package muldiv_pkg;

  localparam int unsigned N_ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StRun,
    StFix,
    StDone
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step
// on the {acc, mq} pair.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mq_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    addend   = mq[0] ? operand : '0;
    sum      = {1'b0, acc} + {1'b0, addend};
    // Divide shifts the next dividend bit into the partial remainder.
    shifted  = {acc, mq[WIDTH-1]};
    diff     = shifted - {1'b0, operand};
    acc_next = sum[WIDTH:1];
    mq_next  = {sum[0], mq[WIDTH-1:1]};
    if (is_div) begin
      if (shifted >= {1'b0, operand}) begin
        acc_next = diff[WIDTH-1:0];
        mq_next  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        mq_next  = {mq[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu unit with HI/LO registers and mthi/mtlo write port.
// Fixed latency: PREP, N_ITER RUN cycles, FIX, then a one-cycle DONE.
module muldiv_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned N_ITER = muldiv_pkg::N_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import muldiv_pkg::*;

  localparam int unsigned CntW = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  muldiv_state_e    state_q;
  muldiv_op_e       op_e;
  logic             is_div_q, is_signed_q, neg_main_q, neg_rem_q, b_zero_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, mq_q, operand_q, hi_q, lo_q;
  logic [CntW-1:0]  cnt_q;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b, step_acc, step_mq;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix, hi_res, lo_res;

  assign op_e = muldiv_op_e'(op);

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .mq       (mq_q),
    .operand  (operand_q),
    .acc_next (step_acc),
    .mq_next  (step_mq)
  );

  always_comb begin
    sign_a   = is_signed_q & a_q[WIDTH-1];
    sign_b   = is_signed_q & b_q[WIDTH-1];
    abs_a    = sign_a ? -a_q : a_q;
    abs_b    = sign_b ? -b_q : b_q;
    prod     = {acc_q, mq_q};
    prod_fix = neg_main_q ? -prod : prod;
    q_fix    = neg_main_q ? -mq_q : mq_q;
    r_fix    = neg_rem_q ? -acc_q : acc_q;
    if (!is_div_q) begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end else if (b_zero_q) begin
      // Divide by zero: the magnitude path would mis-sign these, so force them.
      hi_res = a_q;
      lo_res = '1;
    end else begin
      hi_res = r_fix;
      lo_res = q_fix;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      neg_main_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      b_zero_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      mq_q        <= '0;
      operand_q   <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hi_wr) hi_q <= wr_data;
          if (lo_wr) lo_q <= wr_data;
          if (start) begin
            is_div_q    <= (op_e == OP_DIV) || (op_e == OP_DIVU);
            is_signed_q <= (op_e == OP_MULT) || (op_e == OP_DIV);
            a_q         <= a;
            b_q         <= b;
            state_q     <= StPrep;
          end
        end
        StPrep: begin
          acc_q      <= '0;
          mq_q       <= is_div_q ? abs_a : abs_b;
          operand_q  <= is_div_q ? abs_b : abs_a;
          neg_main_q <= sign_a ^ sign_b;
          neg_rem_q  <= sign_a;
          b_zero_q   <= (b_q == '0);
          cnt_q      <= '0;
          state_q    <= StRun;
        end
        StRun: begin
          acc_q <= step_acc;
          mq_q  <= step_mq;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(N_ITER - 1)) state_q <= StFix;
        end
        StFix: begin
          hi_q    <= hi_res;
          lo_q    <= lo_res;
          state_q <= StDone;
        end
        StDone: begin
          if (hi_wr) hi_q <= wr_data;
          if (lo_wr) lo_q <= wr_data;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StPrep) || (state_q == StRun) || (state_q == StFix);
  assign done = (state_q == StDone);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases, overlap/reset cases and a few
// random vectors checked against a language-level arithmetic model.
module tb_muldiv_unit;

  logic        clk, rst, start, hi_wr, lo_wr, busy, done;
  logic [1:0]  op;
  logic [31:0] a, b, wr_data, hi, lo;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  muldiv_unit #(
    .WIDTH  (32),
    .N_ITER (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .hi_wr   (hi_wr),
    .lo_wr   (lo_wr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] m_op, input logic [31:0] ma,
                                        input logic [31:0] mb);
    longint pa, pb;
    int sa, sb_i, q, r;
    logic [31:0] qu, ru;
    case (m_op)
      2'b00: begin
        pa = longint'(signed'(ma));
        pb = longint'(signed'(mb));
        return 64'(pa * pb);
      end
      2'b01: return {32'd0, ma} * {32'd0, mb};
      2'b10: begin
        if (mb == 32'd0) return {ma, 32'hFFFF_FFFF};
        if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa   = signed'(ma);
        sb_i = signed'(mb);
        q    = sa / sb_i;
        r    = sa % sb_i;
        return {32'(r), 32'(q)};
      end
      default: begin
        if (mb == 32'd0) return {ma, 32'hFFFF_FFFF};
        qu = ma / mb;
        ru = ma % mb;
        return {ru, qu};
      end
    endcase
  endfunction

  // Launches one op, optionally injecting an ignored start + lo_wr at cycle poke_at.
  task automatic run_op(input string tag, input logic [1:0] op_v, input logic [31:0] a_v,
                        input logic [31:0] b_v, input logic [63:0] exp, input int poke_at);
    int k;
    int busy_cnt;
    logic [63:0] e;
    sb.push_back(exp);
    op = op_v; a = a_v; b = b_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    busy_cnt = 0;
    while (!done && k < 100) begin
      if (busy) busy_cnt++;
      if (k == poke_at) begin
        start = 1'b1; op = 2'b01; a = 32'h1; b = 32'h1;
        lo_wr = 1'b1; wr_data = 32'h1234;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lo_wr = 1'b0;
      k++;
    end
    check({tag, ":latency"}, 64'(k), 64'd35);
    check({tag, ":busy_cycles"}, 64'(busy_cnt), 64'd34);
    check({tag, ":busy_in_done"}, 64'(busy), 64'd0);
    e = sb.pop_front();
    check({tag, ":hi"}, 64'(hi), 64'(e[63:32]));
    check({tag, ":lo"}, 64'(lo), 64'(e[31:0]));
    @(posedge clk); #1;
    check({tag, ":done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
    #1;
    check("reset:busy", 64'(busy), 64'd0);
    check("reset:done", 64'(done), 64'd0);
    check("reset:hi", 64'(hi), 64'd0);
    check("reset:lo", 64'(lo), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, -1);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, -1);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, -1);
    run_op("divu_7_2", 2'b11, 32'd7, 32'd2, {32'd1, 32'd3}, -1);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, -1);
    run_op("divu_by0", 2'b11, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, -1);
    run_op("div_by0", 2'b10, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, -1);

    // RUN cycle 5 is start + 7 cycles.
    run_op("overlap", 2'b01, 32'd1000, 32'd1000, {32'd0, 32'd1_000_000}, 7);
    lo_wr = 1'b1; wr_data = 32'h1234;
    @(posedge clk); #1;
    lo_wr = 1'b0;
    check("mtlo:lo", 64'(lo), 64'h1234);
    check("mtlo:hi_kept", 64'(hi), 64'd0);
    hi_wr = 1'b1; wr_data = 32'hABCD;
    @(posedge clk); #1;
    hi_wr = 1'b0;
    check("mthi:hi", 64'(hi), 64'hABCD);

    for (int i = 0; i < 8; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = (i == 5) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 300)) : $urandom);
      run_op($sformatf("rand%0d", i), r_op, r_a, r_b, model(r_op, r_a, r_b), -1);
    end

    // Abort mid-RUN with async reset; the discarded op never reaches the scoreboard.
    op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort:busy", 64'(busy), 64'd0);
    check("abort:done", 64'(done), 64'd0);
    check("abort:hi", 64'(hi), 64'd0);
    check("abort:lo", 64'(lo), 64'd0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 2'b01, 32'd3, 32'd5, {32'd0, 32'd15}, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
